// File: rtl/demux_dispatch_1x4.sv
// Registered 1-to-4 stream dispatcher: each accepted word is steered by in_sel or
// round-robin into one of four per-channel FIFOs, so a stalled consumer only
// blocks words headed for its own channel.
module demux_dispatch_1x4 #(
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned RR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [1:0]        in_sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [4*DW-1:0]   out_data,
    output logic [1:0]        rr_ptr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [1:0] r_rr_ptr;
    logic [1:0] w_tgt;
    logic [3:0] w_full;
    logic [3:0] w_empty;
    logic       w_accept;

    // Destination comes only from registered state or in_sel, never from out_ready
    always_comb begin
        w_tgt    = (RR_MODE != 0) ? r_rr_ptr : in_sel;
        in_ready = ~w_full[w_tgt];
        w_accept = in_valid & in_ready;
        rr_ptr   = (RR_MODE != 0) ? r_rr_ptr : 2'd0;
    end

    // Round-robin pointer moves only when a word is actually taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
        end else if ((RR_MODE != 0) && w_accept) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_ch
        logic [DW-1:0] r_mem [DEPTH];
        logic [PW-1:0] r_wr_ptr;
        logic [PW-1:0] r_rd_ptr;
        logic          w_push;
        logic          w_pop;

        // Occupancy from extra-MSB pointers; full is judged before this cycle's pop
        always_comb begin
            w_empty[n] = (r_wr_ptr == r_rd_ptr);
            w_full[n]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
            w_push     = w_accept && (w_tgt == 2'(n));
            w_pop      = ~w_empty[n] & out_ready[n];
            out_valid[n]            = ~w_empty[n];
            out_data[n*DW +: DW]    = w_empty[n] ? '0 : r_mem[r_rd_ptr[AW-1:0]];
        end

        // Pointer state; reset empties the channel immediately
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end

        // Storage needs no reset: contents are masked whenever the channel is empty
        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux_dispatch_1x4.sv
// Bench for demux_dispatch_1x4: one select-mode and one round-robin instance,
// a queue-level reference model, a per-cycle compare process and directed cases.
module tb_demux_dispatch_1x4;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        iv;
    logic [1:0]        ir;
    logic [1:0][1:0]   isel;
    logic [1:0][1:0]   rp;
    logic [1:0][7:0]   idata;
    logic [1:0][3:0]   ov;
    logic [1:0][3:0]   ordy;
    logic [1:0][31:0]  od;

    demux_dispatch_1x4 #(.DW(8), .DEPTH(DEPTH), .RR_MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
        .in_sel(isel[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .rr_ptr(rp[0]));

    demux_dispatch_1x4 #(.DW(8), .DEPTH(DEPTH), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
        .in_sel(isel[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .rr_ptr(rp[1]));

    // Reference model: per instance, four bounded lists with explicit levels
    logic [7:0] mq  [2][4][DEPTH];
    int         lvl [2][4];
    int         mrr [2];
    bit         acc_last [2];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input int m);
        return (m == 1) ? mrr[m] : int'(isel[m]);
    endfunction

    // Model update on every clock edge (and asynchronously on reset)
    initial begin
        for (int m = 0; m < 2; m++) begin
            mrr[m] = 0; acc_last[m] = 0;
            for (int c = 0; c < 4; c++) lvl[m][c] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int m = 0; m < 2; m++) begin
                    mrr[m] = 0; acc_last[m] = 0;
                    for (int c = 0; c < 4; c++) lvl[m][c] = 0;
                end
            end else begin
                for (int m = 0; m < 2; m++) begin
                    int t;
                    bit acc;
                    t   = tgt_of(m);
                    acc = iv[m] && (lvl[m][t] < DEPTH);
                    for (int c = 0; c < 4; c++) begin
                        if (lvl[m][c] > 0 && ordy[m][c]) begin
                            for (int k = 0; k < DEPTH - 1; k++) mq[m][c][k] = mq[m][c][k+1];
                            lvl[m][c]--;
                        end
                    end
                    if (acc) begin
                        mq[m][t][lvl[m][t]] = idata[m];
                        lvl[m][t]++;
                        if (m == 1) mrr[m] = (mrr[m] + 1) % 4;
                    end
                    acc_last[m] = acc;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int m = 0; m < 2; m++) begin
                    logic [3:0]  e_ov;
                    logic [31:0] e_od;
                    e_ov = '0;
                    e_od = '0;
                    for (int c = 0; c < 4; c++) begin
                        if (lvl[m][c] > 0) begin
                            e_ov[c]       = 1'b1;
                            e_od[c*8 +: 8] = mq[m][c][0];
                        end
                    end
                    check($sformatf("m%0d_in_ready", m), 32'(ir[m]),
                          32'(lvl[m][tgt_of(m)] < DEPTH));
                    check($sformatf("m%0d_out_valid", m), 32'(ov[m]), 32'(e_ov));
                    check($sformatf("m%0d_out_data", m), od[m], e_od);
                    check($sformatf("m%0d_rr_ptr", m), 32'(rp[m]), 32'((m == 1) ? mrr[m] : 0));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; iv = '0; isel = '0; idata = '0; ordy = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(ir), 32'(2'b11));
        check("rst_out_valid", 32'({ov[1], ov[0]}), 32'h0);
        check("rst_out_data0", od[0], 32'h0);
        check("rst_rr_ptr", 32'(rp[1]), 32'h0);

        // Select routing: each word shows only on its own channel one cycle later
        tick;
        ordy[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            iv[0] = 1'b1; isel[0] = 2'(i); idata[0] = 8'(8'hA0 + i);
            tick;
            check("sel_valid", 32'(ov[0]), 32'(1) << i);
            check("sel_data", od[0], 32'(8'hA0 + i) << (8 * i));
        end
        iv[0] = 1'b0;
        tick;
        check("sel_drained", 32'(ov[0]), 32'h0);

        // Backpressure on channel 2 while channel 1 keeps flowing
        ordy[0] = 4'b1011;
        iv[0] = 1'b1; isel[0] = 2'd2; idata[0] = 8'hB0; settle;
        check("bp_rdy_b0", 32'(ir[0]), 32'h1);
        tick;
        idata[0] = 8'hB1; settle;
        check("bp_rdy_b1", 32'(ir[0]), 32'h1);
        tick;
        isel[0] = 2'd1; idata[0] = 8'hC0; settle;
        check("bp_rdy_other", 32'(ir[0]), 32'h1);
        tick;
        isel[0] = 2'd2; idata[0] = 8'hB2; settle;
        check("bp_full", 32'(ir[0]), 32'h0);
        check("bp_head_b0", 32'(od[0][23:16]), 32'hB0);
        tick;
        check("bp_still_full", 32'(ir[0]), 32'h0);
        ordy[0] = 4'hF;
        tick;
        check("bp_resume", 32'(ir[0]), 32'h1);
        check("bp_head_b1", 32'(od[0][23:16]), 32'hB1);
        tick;
        iv[0] = 1'b0;
        check("bp_head_b2", 32'(od[0][23:16]), 32'hB2);
        tick;
        check("bp_empty", 32'(ov[0][2]), 32'h0);

        // Simultaneous push and pop on channel 0 at level 1
        ordy[0] = 4'b0000;
        iv[0] = 1'b1; isel[0] = 2'd0; idata[0] = 8'hD0;
        tick;
        ordy[0] = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            idata[0] = 8'(8'hD0 + k); settle;
            check("pp_ready", 32'(ir[0]), 32'h1);
            tick;
            check("pp_valid", 32'(ov[0][0]), 32'h1);
            check("pp_head", 32'(od[0][7:0]), 32'(8'hD0 + k));
        end
        iv[0] = 1'b0;
        tick; tick;

        // Round-robin distribution: eight words fill all four channels
        ordy[1] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            check("rr_seq", 32'(rp[1]), 32'(i % 4));
            iv[1] = 1'b1; idata[1] = 8'(8'h10 + i); isel[1] = 2'($urandom);
            tick;
        end
        iv[1] = 1'b0;
        check("rr_wrap", 32'(rp[1]), 32'h0);
        check("rr_all_full", 32'(ir[1]), 32'h0);
        check("rr_valid", 32'(ov[1]), 32'hF);
        check("rr_heads1", od[1], 32'h13121110);
        ordy[1] = 4'hF;
        tick;
        check("rr_heads2", od[1], 32'h17161514);
        tick;
        check("rr_drained", 32'(ov[1]), 32'h0);

        // Strict round-robin stall: channel 1 full blocks input though 2/3 are empty
        ordy[1] = 4'b1101;
        for (int i = 0; i < 9; i++) begin
            iv[1] = 1'b1; idata[1] = 8'(8'h30 + i);
            tick;
        end
        idata[1] = 8'h39;
        tick;
        check("st_ready", 32'(ir[1]), 32'h0);
        check("st_valid", 32'(ov[1]), 32'b0010);
        check("st_ptr", 32'(rp[1]), 32'h1);
        ordy[1] = 4'hF;
        tick;
        ordy[1] = 4'b1101;
        check("st_resume", 32'(ir[1]), 32'h1);
        check("st_ptr_hold", 32'(rp[1]), 32'h1);
        tick;
        iv[1] = 1'b0;
        check("st_ptr_adv", 32'(rp[1]), 32'h2);
        check("st_head", 32'(od[1][15:8]), 32'h35);
        ordy[1] = 4'hF;
        tick; tick; tick;

        // Randomized traffic with a mid-traffic asynchronous reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                check("mid_rst_valid", 32'({ov[1], ov[0]}), 32'h0);
                check("mid_rst_data", od[0] | od[1], 32'h0);
                check("mid_rst_ptr", 32'(rp[1]), 32'h0);
                iv = '0;
                #3 rst = 1'b0;
                tick;
            end
            for (int m = 0; m < 2; m++) begin
                if (!(iv[m] && !acc_last[m])) begin
                    iv[m]    = ($urandom_range(0, 3) != 0);
                    idata[m] = 8'($urandom);
                    isel[m]  = 2'($urandom);
                end
                ordy[m] = 4'($urandom);
            end
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
